// File: rtl/rng_pkg.sv
// Shared types and constants for the LFSR random-number arbiter.
// The seed sanitiser lives here so any other LFSR user can apply the same rule.
package rng_pkg;

    localparam int unsigned LFSR_W = 64;
    localparam logic [LFSR_W-1:0] LFSR_LOCKUP = '1;
    localparam logic [LFSR_W-1:0] SEED_SANE   = LFSR_W'(1);

    typedef enum logic [1:0] {
        SEED = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_t;

    // The all-ones pattern locks an XNOR LFSR, so it is swapped for a safe value
    function automatic logic [LFSR_W-1:0] sanitize_seed(input logic [LFSR_W-1:0] s);
        return (s == LFSR_LOCKUP) ? SEED_SANE : s;
    endfunction

endpackage

// File: rtl/lfsr64.sv
// Free-running 64-bit XNOR LFSR, taps 64,63,61,60; loads seed while reset is high.
// New bit enters at the LSB; the state is exposed directly on shift_seed.
module lfsr64
    import rng_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] shift_seed
);

    logic feedback;

    assign feedback = ~(shift_seed[63] ^ shift_seed[62] ^ shift_seed[60] ^ shift_seed[59]);

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_seed <= seed;
        end else begin
            shift_seed <= {shift_seed[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin sharing of one free-running LFSR among NREQ requesters, with
// seeding, warm-up discard and a minimum spacing between delivered words.
module lfsr_rng_arbiter
    import rng_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WARMUP = 128,
    parameter int unsigned GAP    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LFSR_W-1:0] seed,
    input  logic              seed_load,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic [LFSR_W-1:0] rnd_out,
    output logic              rnd_valid,
    output logic              busy
);

    localparam int unsigned PTR_W  = $clog2(NREQ);
    localparam int unsigned WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int unsigned GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic [NREQ-1:0]     gnt_d;
    logic [LFSR_W-1:0]   rnd_d;
    logic                valid_d;
    logic                busy_d;
    logic [LFSR_W-1:0]   seed_q;
    logic [LFSR_W-1:0]   lfsr_seed;
    logic [LFSR_W-1:0]   lfsr_state;
    logic                lfsr_reset;
    logic [PTR_W:0]      pick;

    // MSB flags a hit; low bits give the first requester at or after p, wrapping
    function automatic logic [PTR_W:0] rr_pick(input logic [NREQ-1:0]  r,
                                               input logic [PTR_W-1:0] p);
        logic [PTR_W:0] res;
        int unsigned    idx;
        res = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(p) + i) % NREQ;
            if (!res[PTR_W] && r[PTR_W'(idx)]) begin
                res = {1'b1, PTR_W'(idx)};
            end
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
        return PTR_W'((32'(g) + 32'd1) % NREQ);
    endfunction

    assign lfsr_seed  = sanitize_seed(seed_q);
    assign lfsr_reset = reset | (state_q == SEED);
    assign pick       = rr_pick(req, ptr_q);

    lfsr64 u_lfsr64 (
        .seed       (lfsr_seed),
        .clk        (clk),
        .reset      (lfsr_reset),
        .shift_seed (lfsr_state)
    );

    // Next-state and registered-output decode; a reseed pre-empts any grant
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        warm_d  = warm_q;
        gnt_d   = '0;
        valid_d = 1'b0;
        rnd_d   = rnd_out;
        busy_d  = busy;

        if (seed_load) begin
            state_d = SEED;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                SEED: begin
                    state_d = WARM;
                    warm_d  = WARM_W'(WARMUP - 1);
                    busy_d  = 1'b1;
                end
                WARM: begin
                    busy_d = 1'b1;
                    if (warm_q == '0) begin
                        state_d = RUN;
                        gap_d   = '0;
                        busy_d  = 1'b0;
                    end else begin
                        warm_d = warm_q - WARM_W'(1);
                    end
                end
                RUN: begin
                    busy_d = 1'b0;
                    if (gap_q == '0) begin
                        if (pick[PTR_W]) begin
                            gnt_d   = NREQ'(1) << pick[PTR_W-1:0];
                            valid_d = 1'b1;
                            rnd_d   = lfsr_state;
                            ptr_d   = next_ptr(pick[PTR_W-1:0]);
                            gap_d   = GAP_W'(GAP - 1);
                        end
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_d = SEED;
                    busy_d  = 1'b1;
                end
            endcase
        end
    end

    // Seed is captured during reset and on a reseed pulse, then held for SEED
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEED;
            ptr_q     <= '0;
            gap_q     <= '0;
            warm_q    <= '0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_out   <= '0;
            busy      <= 1'b1;
            seed_q    <= seed;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gap_q     <= gap_d;
            warm_q    <= warm_d;
            gnt       <= gnt_d;
            rnd_valid <= valid_d;
            rnd_out   <= rnd_d;
            busy      <= busy_d;
            if (seed_load) begin
                seed_q <= seed;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Randomised bench for lfsr_rng_arbiter against a cycle-level behavioural model
// built from phase counting, grant spacing and a software XNOR LFSR.
module tb_lfsr_rng_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned WARMUP = 128;
    localparam int unsigned GAP    = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [63:0]     seed;
    logic            seed_load;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [63:0]     rnd_out;
    logic            rnd_valid;
    logic            busy;

    int total = 0;
    int bad   = 0;

    // Model: phase = cycles since the seed event (0 is the seeding cycle)
    int unsigned     m_phase;
    int unsigned     m_since;
    int unsigned     m_ptr;
    logic [63:0]     m_seed;
    logic [63:0]     m_lfsr;
    logic [63:0]     m_rnd;
    logic [NREQ-1:0] m_gnt;
    logic            m_valid;
    logic            m_busy;

    always #5 clk = ~clk;

    lfsr_rng_arbiter #(
        .NREQ   (NREQ),
        .WARMUP (WARMUP),
        .GAP    (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .seed      (seed),
        .seed_load (seed_load),
        .req       (req),
        .gnt       (gnt),
        .rnd_out   (rnd_out),
        .rnd_valid (rnd_valid),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Taps are numbered 1..64, tap n being bit n-1; XNOR feedback enters at bit 0
    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        logic fb;
        fb = ~(s[64-1] ^ s[63-1] ^ s[61-1] ^ s[60-1]);
        return {s[62:0], fb};
    endfunction

    function automatic logic [63:0] sane(input logic [63:0] s);
        return (s == 64'hFFFF_FFFF_FFFF_FFFF) ? 64'h1 : s;
    endfunction

    function automatic bit would_grant(input logic [NREQ-1:0] r);
        return (m_phase > WARMUP) && (m_since + 1 >= GAP) && (r != '0);
    endfunction

    task automatic model_edge();
        int unsigned g;
        bit          found;
        if (reset) begin
            m_phase = 0;
            m_seed  = seed;
            m_ptr   = 0;
            m_since = GAP;
            m_gnt   = '0;
            m_valid = 1'b0;
            m_rnd   = '0;
            m_busy  = 1'b1;
        end else if (seed_load) begin
            m_phase = 0;
            m_seed  = seed;
            m_since = GAP;
            m_gnt   = '0;
            m_valid = 1'b0;
            m_busy  = 1'b1;
        end else begin
            m_gnt   = '0;
            m_valid = 1'b0;
            if (m_since < GAP) m_since++;
            if (m_phase > WARMUP && m_since >= GAP && req != '0) begin
                found = 1'b0;
                g     = 0;
                for (int k = 0; k < int'(NREQ); k++) begin
                    if (!found && req[(m_ptr + k) % NREQ]) begin
                        found = 1'b1;
                        g     = (m_ptr + k) % NREQ;
                    end
                end
                m_gnt[g] = 1'b1;
                m_valid  = 1'b1;
                m_rnd    = m_lfsr;
                m_ptr    = (g + 1) % NREQ;
                m_since  = 0;
            end
            m_phase++;
            m_busy = (m_phase <= WARMUP);
        end
        if (m_phase == 1) m_lfsr = sane(m_seed);
        else if (m_phase > 1) m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic step(input logic rst, input logic sl, input logic [NREQ-1:0] rq);
        @(negedge clk);
        reset     = rst;
        seed_load = sl;
        req       = rq;
        @(posedge clk);
        model_edge();
        #1;
        check("gnt",       64'(gnt),       64'(m_gnt));
        check("rnd_valid", 64'(rnd_valid), 64'(m_valid));
        check("busy",      64'(busy),      64'(m_busy));
        check("rnd_out",   rnd_out,        m_rnd);
    endtask

    initial begin
        bit hit;
        reset     = 1'b1;
        seed_load = 1'b0;
        req       = '0;
        seed      = 64'h1;

        // Reset with seed 1, then idle through the full warm-up
        repeat (3) step(1'b1, 1'b0, '0);
        for (int i = 0; i < 140; i++) step(1'b0, 1'b0, '0);

        // All requesting: round-robin order and fixed spacing
        for (int i = 0; i < 5 * int'(GAP) + 10; i++) step(1'b0, 1'b0, 4'b1111);

        // Park the pointer at 3, then request only index 2 to force a wrap
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            step(1'b0, 1'b0, 4'b1111);
            if (m_ptr == 3 && m_valid) hit = 1'b1;
        end
        check("ptr3_reached", 64'(hit), 64'(1));
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step(1'b0, 1'b0, 4'b0100);
            if (m_valid) begin
                hit = 1'b1;
                check("wrap_gnt", 64'(gnt), 64'(4'b0100));
            end
        end
        check("wrap_seen", 64'(hit), 64'(1));
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step(1'b0, 1'b0, 4'b1111);
            if (m_valid) begin
                hit = 1'b1;
                check("after_wrap_gnt", 64'(gnt), 64'(4'b1000));
            end
        end
        check("after_wrap_seen", 64'(hit), 64'(1));

        // Reseed exactly on a cycle that would otherwise grant
        seed = 64'hDEAD_BEEF_0123_4567;
        hit  = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (would_grant(4'b1111)) begin
                hit = 1'b1;
                step(1'b0, 1'b1, 4'b1111);
                check("sl_no_gnt", 64'(gnt), 64'(0));
            end else begin
                step(1'b0, 1'b0, 4'b1111);
            end
        end
        check("sl_collide_seen", 64'(hit), 64'(1));
        for (int i = 0; i < int'(WARMUP) + 2 * int'(GAP) + 5; i++) step(1'b0, 1'b0, 4'b1111);

        // Lock-up seed must behave as seed 1
        seed = 64'hFFFF_FFFF_FFFF_FFFF;
        step(1'b0, 1'b1, 4'b0000);
        for (int i = 0; i < int'(WARMUP) + 2 * int'(GAP) + 5; i++) step(1'b0, 1'b0, 4'b0011);

        // Reset landing on a pending grant
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (would_grant(4'b1111)) begin
                hit = 1'b1;
                step(1'b1, 1'b1, 4'b1111);
                check("rst_rnd_zero", rnd_out, 64'h0);
            end else begin
                step(1'b0, 1'b0, 4'b1111);
            end
        end
        check("rst_collide_seen", 64'(hit), 64'(1));
        for (int i = 0; i < int'(WARMUP) + int'(GAP) + 5; i++) step(1'b0, 1'b0, 4'b0010);

        // Random traffic with occasional reseeds and resets
        for (int i = 0; i < 3000; i++) begin
            logic            rs;
            logic            sl;
            logic [NREQ-1:0] rq;
            rs = ($urandom_range(0, 999) == 0);
            sl = ($urandom_range(0, 399) == 0);
            rq = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) seed = {$urandom, $urandom};
            if ($urandom_range(0, 50) == 0) seed = 64'hFFFF_FFFF_FFFF_FFFF;
            step(rs, sl, rq);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
